// File: rtl/sipo_deser.sv
// -----------------------------------------------------------------------------
// sipo_deser
//   Serial-to-parallel deserializer. Collects one bit per `enable` strobe into
//   WIDTH-bit words framed by a `sync` marker on the first bit, and presents
//   each completed word on a one-entry valid/ready output buffer. A word that
//   completes while the buffer is full (and not draining) is dropped and
//   flagged with a one-cycle `overrun` pulse.
//
//   Compile-time option: define SIPO_PARITY_EN to expect one even-parity bit
//   after every word and report the check result on `parity_err`.
//
// Parameters
//   WIDTH      bits per word (>= 2)
//   MSB_FIRST  0: first bit lands in data_out[0]; 1: in data_out[WIDTH-1]
//
// Ports
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   data_in    serial bit, sampled when enable=1
//   enable     bit strobe
//   sync       start-of-word marker, qualified by enable
//   data_out   completed word
//   out_valid  data_out holds an unconsumed word
//   out_ready  downstream accepts the word
//   overrun    one-cycle pulse: a completed word was dropped
//   parity_err parity check result for the buffered word (SIPO_PARITY_EN only)
// -----------------------------------------------------------------------------
module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             data_in,
  input  logic             enable,
  input  logic             sync,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
`ifdef SIPO_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;

  logic [CW-1:0]    cap_idx;
  logic [CW-1:0]    pos;
  logic [WIDTH-1:0] word_next;
  logic             word_done;
  logic [WIDTH-1:0] done_word;
`ifdef SIPO_PARITY_EN
  logic             done_perr;
`endif

  // Collection register with the current bit merged in. A sync bit always
  // restarts at bit 0 regardless of where the previous word stood.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise a latch would be inferred.
  always_comb begin
    cap_idx   = sync ? '0 : cnt;
    pos       = (MSB_FIRST != 0) ? (LAST - cap_idx) : cap_idx;
    word_next = sync ? '0 : shreg;
    word_next[pos] = data_in;
`ifdef SIPO_PARITY_EN
    // The word is already complete in shreg; this bit is the parity bit.
    word_done = enable && !sync && (state == PAR);
    done_word = shreg;
    done_perr = data_in ^ (^shreg);
`else
    word_done = enable && !sync && (state == SHIFT) && (cnt == LAST);
    done_word = word_next;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and later statements in this block
  // override earlier ones for the same register (used for transfer vs. load).
  // NOTE: shreg is a small collection register, not a memory array, so it is
  // reset along with the rest of the state to keep outputs deterministic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      data_out   <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      overrun <= 1'b0;

      // Bit collection; everything holds while enable is low.
      if (enable) begin
        if (sync) begin
          // Start (or restart) a word: this bit is bit 0.
          shreg <= word_next;
          cnt   <= CW'(1);
          state <= SHIFT;
        end else begin
          case (state)
            SHIFT: begin
              shreg <= word_next;
              if (cnt == LAST) begin
                cnt   <= '0;
`ifdef SIPO_PARITY_EN
                state <= PAR;
`else
                state <= IDLE;
`endif
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
`ifdef SIPO_PARITY_EN
            PAR:     state <= IDLE;
`endif
            default: ; // IDLE: unframed bits are ignored
          endcase
        end
      end

      // Output buffer: a transfer empties it; a completion on the same edge
      // refills it. Otherwise a completion into a full buffer is dropped.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
`ifdef SIPO_PARITY_EN
        parity_err <= 1'b0;
`endif
      end

      if (word_done) begin
        if (!out_valid || out_ready) begin
          data_out  <= done_word;
          out_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
          parity_err <= done_perr;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// -----------------------------------------------------------------------------
// tb_sipo_deser
//   Directed bench for sipo_deser with WIDTH=4. Two instances share all
//   inputs: one LSB-first, one MSB-first. With SIPO_PARITY_EN defined every
//   word is followed by its even-parity bit, plus dedicated parity cases.
// -----------------------------------------------------------------------------
module tb_sipo_deser;

  logic       clk;
  logic       reset_n;
  logic       data_in;
  logic       enable;
  logic       sync;
  logic       out_ready;
  logic [3:0] data_out_l, data_out_m;
  logic       out_valid_l, out_valid_m;
  logic       overrun_l, overrun_m;
`ifdef SIPO_PARITY_EN
  logic       parity_err_l, parity_err_m;
`endif

  int vectors     = 0;
  int miscompares = 0;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
    .clk       (clk),
    .reset_n   (reset_n),
    .data_in   (data_in),
    .enable    (enable),
    .sync      (sync),
    .data_out  (data_out_l),
    .out_valid (out_valid_l),
    .out_ready (out_ready),
    .overrun   (overrun_l)
`ifdef SIPO_PARITY_EN
    ,
    .parity_err(parity_err_l)
`endif
  );

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
    .clk       (clk),
    .reset_n   (reset_n),
    .data_in   (data_in),
    .enable    (enable),
    .sync      (sync),
    .data_out  (data_out_m),
    .out_valid (out_valid_m),
    .out_ready (out_ready),
    .overrun   (overrun_m)
`ifdef SIPO_PARITY_EN
    ,
    .parity_err(parity_err_m)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1 time unit so outputs are sampled off-edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic s);
    enable  = 1'b1;
    data_in = b;
    sync    = s;
    tick();
    enable  = 1'b0;
    sync    = 1'b0;
    data_in = 1'b0;
  endtask

  // Sends w[0] first with sync, then w[1..3], then the even-parity bit.
  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) send_bit(w[i], i == 0);
`ifdef SIPO_PARITY_EN
    send_bit(^w, 1'b0);
`endif
  endtask

  initial begin
    reset_n   = 1'b0;
    data_in   = 1'b0;
    enable    = 1'b0;
    sync      = 1'b0;
    out_ready = 1'b1;
    #12;

    // Reset state
    check("rst_data_l",  32'(data_out_l), 32'h0);
    check("rst_valid_l", 32'(out_valid_l), 32'h0);
    check("rst_ovr_l",   32'(overrun_l),  32'h0);
    check("rst_data_m",  32'(data_out_m), 32'h0);
`ifdef SIPO_PARITY_EN
    check("rst_perr_l",  32'(parity_err_l), 32'h0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Bits 1,0,1,1 with sync on the first: LSB-first 0xD, MSB-first 0xB
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check("w1_valid_before", 32'(out_valid_l), 32'h0);
    send_bit(1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
    check("w1_valid_before_par", 32'(out_valid_l), 32'h0);
    send_bit(1'b1, 1'b0);
`endif
    check("w1_valid_l", 32'(out_valid_l), 32'h1);
    check("w1_data_l",  32'(data_out_l),  32'hD);
    check("w1_valid_m", 32'(out_valid_m), 32'h1);
    check("w1_data_m",  32'(data_out_m),  32'hB);
    tick();
    check("w1_valid_drop", 32'(out_valid_l), 32'h0);
    check("w1_data_keep",  32'(data_out_l),  32'hD);

    // out_ready=0: 0x3 buffered, 0x5 dropped with one-cycle overrun
    out_ready = 1'b0;
    send_word(4'h3);
    check("ov_first_valid", 32'(out_valid_l), 32'h1);
    check("ov_first_data",  32'(data_out_l),  32'h3);
    check("ov_first_noovr", 32'(overrun_l),   32'h0);
    send_word(4'h5);
    check("ov_pulse",     32'(overrun_l),  32'h1);
    check("ov_hold_data", 32'(data_out_l), 32'h3);
    tick();
    check("ov_pulse_end",  32'(overrun_l),   32'h0);
    check("ov_still_valid", 32'(out_valid_l), 32'h1);
    out_ready = 1'b1;
    check("ov_before_xfer", 32'(data_out_l), 32'h3);
    tick();
    check("ov_after_xfer", 32'(out_valid_l), 32'h0);

    // Sync re-asserted after two bits, then 0,1,1,0: one word 0x6
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    check("rs_no_early", 32'(out_valid_l), 32'h0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
    send_bit(1'b0, 1'b0);
`endif
    check("rs_valid", 32'(out_valid_l), 32'h1);
    check("rs_data",  32'(data_out_l),  32'h6);
    check("rs_noovr", 32'(overrun_l),   32'h0);
    tick();
    check("rs_single", 32'(out_valid_l), 32'h0);

    // Reset mid-word with 0xA buffered
    out_ready = 1'b0;
    send_word(4'hA);
    check("rm_buf_data", 32'(data_out_l), 32'hA);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    check("rm_data_l",  32'(data_out_l),  32'h0);
    check("rm_valid_l", 32'(out_valid_l), 32'h0);
    check("rm_ovr_l",   32'(overrun_l),   32'h0);
    check("rm_valid_m", 32'(out_valid_m), 32'h0);
`ifdef SIPO_PARITY_EN
    check("rm_perr_l",  32'(parity_err_l), 32'h0);
`endif
    tick();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    // Unframed bit must be ignored after reset (state back in IDLE)
    send_bit(1'b1, 1'b0);
    // Word 0x9 with idle gaps in between bits
    send_bit(1'b1, 1'b1);
    tick();
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    tick();
    tick();
    check("rm_gap_hold", 32'(out_valid_l), 32'h0);
    send_bit(1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
    send_bit(1'b0, 1'b0);
`endif
    check("rm_new_valid", 32'(out_valid_l), 32'h1);
    check("rm_new_data",  32'(data_out_l),  32'h9);
    check("rm_new_data_m", 32'(data_out_m), 32'h9);
    tick();

`ifdef SIPO_PARITY_EN
    // Data 0x7 with correct parity 1 -> no error
    for (int i = 0; i < 4; i++) send_bit(1'b1 & (i < 3), i == 0);
    send_bit(1'b1, 1'b0);
    check("par_ok_data", 32'(data_out_l),   32'h7);
    check("par_ok_err",  32'(parity_err_l), 32'h0);
    tick();
    // Data 0x7 with wrong parity 0 -> error, word still delivered
    for (int i = 0; i < 4; i++) send_bit(1'b1 & (i < 3), i == 0);
    send_bit(1'b0, 1'b0);
    check("par_bad_valid", 32'(out_valid_l),  32'h1);
    check("par_bad_data",  32'(data_out_l),   32'h7);
    check("par_bad_err",   32'(parity_err_l), 32'h1);
    tick();
    check("par_err_clear", 32'(parity_err_l), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
